// File: rtl/cmd_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_wb_master
//  Purpose  : Bus-side companion of the core command queue. Arbitrates the
//             two queued command words (slot 0 = instruction, slot 1 = data),
//             runs one classic single-beat Wishbone master cycle at a time and
//             returns the termination to the originating core port while
//             pulsing the per-slot taken/complete handshake.
//  Ports    : clk, rst (async, active-low)
//             cmd_in_0/1    queued i/d command words
//             cmd_taken     per-slot one-cycle pulse, command accepted
//             cmd_complete  per-slot one-cycle pulse, command finished
//             wb_*          Wishbone master side (cyc/stb/we/sel/adr/datw,
//                           ack/err/datr)
//             i_wb_*/d_wb_* termination and read data to core i/d ports
//  Command word layout (CMD_SIZE = 71):
//             [70] VALID  [69] TAKEN  [68] WE  [67:64] SEL
//             [63:32] ADR  [31:0] DATW
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_wb_master #(
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CMD_SIZE      = 71
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CMD_SIZE-1:0] cmd_in_0,
    input  logic [CMD_SIZE-1:0] cmd_in_1,
    output logic [1:0]          cmd_taken,
    output logic [1:0]          cmd_complete,
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic                wb_we,
    output logic [3:0]          wb_sel,
    output logic [31:0]         wb_adr,
    output logic [31:0]         wb_datw,
    input  logic                wb_ack,
    input  logic                wb_err,
    input  logic [31:0]         wb_datr,
    output logic                i_wb_ack,
    output logic                i_wb_err,
    output logic [31:0]         i_wb_datr,
    output logic                d_wb_ack,
    output logic                d_wb_err,
    output logic [31:0]         d_wb_datr
);

    // Command word field positions
    localparam int c_valid    = 70;
    localparam int c_taken    = 69;
    localparam int c_we       = 68;
    localparam int c_sel_lsb  = 64;
    localparam int c_adr_lsb  = 32;
    localparam int c_datw_lsb = 0;

    localparam bit         c_tmo_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] c_tmo_last = (TIMEOUT_CYCLES == 0) ? 8'd0
                                                              : 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_sel,   w_sel_nxt;     // slot owning the current transaction
    logic        r_last,  w_last_nxt;    // slot served last (round-robin)
    logic [7:0]  r_count, w_count_nxt;   // REQ cycles elapsed

    logic        w_cyc_nxt;
    logic        w_we_nxt;
    logic [3:0]  w_bsel_nxt;
    logic [31:0] w_adr_nxt;
    logic [31:0] w_datw_nxt;
    logic [1:0]  w_taken_nxt;
    logic [1:0]  w_cmpl_nxt;
    logic        w_iack_nxt, w_ierr_nxt;
    logic        w_dack_nxt, w_derr_nxt;
    logic [31:0] w_idatr_nxt, w_ddatr_nxt;

    logic              w_elig0, w_elig1, w_pick;
    logic [CMD_SIZE-1:0] w_cmd;
    logic              w_timeout;
    logic              w_rsp_err;
    logic [31:0]       w_rsp_dat;

    assign w_elig0 = cmd_in_0[c_valid] & ~cmd_in_0[c_taken];
    assign w_elig1 = cmd_in_1[c_valid] & ~cmd_in_1[c_taken];

    // Fixed priority favours d; round-robin favours the slot not served last.
    always_comb begin
        w_pick = w_elig1;
        if (w_elig0 && w_elig1) begin
            w_pick = (ARB_MODE == 0) ? 1'b1 : ~r_last;
        end
    end

    assign w_cmd     = w_pick ? cmd_in_1 : cmd_in_0;
    assign w_timeout = c_tmo_en && (r_count == c_tmo_last);

    // A response without a clean ack is an error (err, ack+err, or timeout).
    // Only a clean read ack returns slave data.
    assign w_rsp_err = wb_err | ~wb_ack;
    assign w_rsp_dat = (wb_ack && !wb_err && !wb_we) ? wb_datr : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_count_nxt = 8'd0;
        w_cyc_nxt   = wb_cyc;
        w_we_nxt    = wb_we;
        w_bsel_nxt  = wb_sel;
        w_adr_nxt   = wb_adr;
        w_datw_nxt  = wb_datw;
        w_taken_nxt = 2'b00;
        w_cmpl_nxt  = 2'b00;
        w_iack_nxt  = 1'b0;
        w_ierr_nxt  = 1'b0;
        w_dack_nxt  = 1'b0;
        w_derr_nxt  = 1'b0;
        w_idatr_nxt = 32'd0;
        w_ddatr_nxt = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_state_nxt = S_REQ;
                    w_sel_nxt   = w_pick;
                    w_taken_nxt = w_pick ? 2'b10 : 2'b01;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = w_cmd[c_we];
                    w_bsel_nxt  = w_cmd[c_sel_lsb +: 4];
                    w_adr_nxt   = w_cmd[c_adr_lsb +: 32];
                    w_datw_nxt  = w_cmd[c_datw_lsb +: 32];
                end
            end

            S_REQ: begin
                if (wb_ack || wb_err || w_timeout) begin
                    // Response outputs are loaded here so they appear in the
                    // single RSP cycle, one cycle after the slave terminates.
                    w_state_nxt = S_RSP;
                    w_cyc_nxt   = 1'b0;
                    w_last_nxt  = r_sel;
                    w_cmpl_nxt  = r_sel ? 2'b10 : 2'b01;
                    if (r_sel) begin
                        w_dack_nxt  = ~w_rsp_err;
                        w_derr_nxt  = w_rsp_err;
                        w_ddatr_nxt = w_rsp_dat;
                    end else begin
                        w_iack_nxt  = ~w_rsp_err;
                        w_ierr_nxt  = w_rsp_err;
                        w_idatr_nxt = w_rsp_dat;
                    end
                end else begin
                    w_count_nxt = r_count + 8'd1;
                end
            end

            S_RSP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sel        <= 1'b0;
            r_last       <= 1'b0;
            r_count      <= 8'd0;
            wb_cyc       <= 1'b0;
            wb_stb       <= 1'b0;
            wb_we        <= 1'b0;
            wb_sel       <= 4'd0;
            wb_adr       <= 32'd0;
            wb_datw      <= 32'd0;
            cmd_taken    <= 2'b00;
            cmd_complete <= 2'b00;
            i_wb_ack     <= 1'b0;
            i_wb_err     <= 1'b0;
            i_wb_datr    <= 32'd0;
            d_wb_ack     <= 1'b0;
            d_wb_err     <= 1'b0;
            d_wb_datr    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_last       <= w_last_nxt;
            r_count      <= w_count_nxt;
            wb_cyc       <= w_cyc_nxt;
            wb_stb       <= w_cyc_nxt;
            wb_we        <= w_we_nxt;
            wb_sel       <= w_bsel_nxt;
            wb_adr       <= w_adr_nxt;
            wb_datw      <= w_datw_nxt;
            cmd_taken    <= w_taken_nxt;
            cmd_complete <= w_cmpl_nxt;
            i_wb_ack     <= w_iack_nxt;
            i_wb_err     <= w_ierr_nxt;
            i_wb_datr    <= w_idatr_nxt;
            d_wb_ack     <= w_dack_nxt;
            d_wb_err     <= w_derr_nxt;
            d_wb_datr    <= w_ddatr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_wb_master
//  Purpose  : Directed self-checking bench for cmd_wb_master. Instance 0 uses
//             round-robin arbitration with the default timeout; instance 1
//             uses fixed priority with a 4-cycle timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_wb_master;

    localparam int TB_TAKEN = 69;

    logic        clk;
    logic        rst;
    logic [70:0] cmd0 [2];
    logic [70:0] cmd1 [2];
    logic [1:0]  taken [2];
    logic [1:0]  cmpl [2];
    logic        cyc [2];
    logic        stb [2];
    logic        we [2];
    logic [3:0]  bsel [2];
    logic [31:0] adr [2];
    logic [31:0] datw [2];
    logic        ack [2];
    logic        err [2];
    logic [31:0] datr [2];
    logic        iack [2];
    logic        ierr [2];
    logic [31:0] idatr [2];
    logic        dack [2];
    logic        derr [2];
    logic [31:0] ddatr [2];

    int n_cmp;
    int n_fail;

    cmd_wb_master #(.ARB_MODE(1), .TIMEOUT_CYCLES(255)) dut_rr (
        .clk(clk), .rst(rst),
        .cmd_in_0(cmd0[0]), .cmd_in_1(cmd1[0]),
        .cmd_taken(taken[0]), .cmd_complete(cmpl[0]),
        .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]), .wb_sel(bsel[0]),
        .wb_adr(adr[0]), .wb_datw(datw[0]),
        .wb_ack(ack[0]), .wb_err(err[0]), .wb_datr(datr[0]),
        .i_wb_ack(iack[0]), .i_wb_err(ierr[0]), .i_wb_datr(idatr[0]),
        .d_wb_ack(dack[0]), .d_wb_err(derr[0]), .d_wb_datr(ddatr[0])
    );

    cmd_wb_master #(.ARB_MODE(0), .TIMEOUT_CYCLES(4)) dut_fx (
        .clk(clk), .rst(rst),
        .cmd_in_0(cmd0[1]), .cmd_in_1(cmd1[1]),
        .cmd_taken(taken[1]), .cmd_complete(cmpl[1]),
        .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]), .wb_sel(bsel[1]),
        .wb_adr(adr[1]), .wb_datw(datw[1]),
        .wb_ack(ack[1]), .wb_err(err[1]), .wb_datr(datr[1]),
        .i_wb_ack(iack[1]), .i_wb_err(ierr[1]), .i_wb_datr(idatr[1]),
        .d_wb_ack(dack[1]), .d_wb_err(derr[1]), .d_wb_datr(ddatr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [70:0] mk(input logic w, input logic [3:0] s,
                                       input logic [31:0] a, input logic [31:0] d);
        return {1'b1, 1'b0, w, s, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [144:0] outs;
        rst = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            outs = {cyc[k], stb[k], we[k], bsel[k], adr[k], datw[k], taken[k], cmpl[k],
                    iack[k], ierr[k], idatr[k], dack[k], derr[k], ddatr[k]};
            n_cmp++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", k, outs);
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_d_write();
        cmd1[0] = mk(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
        tick();
        n_cmp++; if (taken[0] !== 2'b10) begin n_fail++; $display("FAIL wr_taken: got %b want 10", taken[0]); end
        n_cmp++; if ({cyc[0], stb[0], we[0]} !== 3'b111) begin n_fail++; $display("FAIL wr_ctrl: got %b want 111", {cyc[0], stb[0], we[0]}); end
        n_cmp++; if ({bsel[0], adr[0], datw[0]} !== {4'hF, 32'h0000_1000, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL wr_fields: got %h %h %h want f 00001000 deadbeef", bsel[0], adr[0], datw[0]); end
        cmd1[0][TB_TAKEN] = 1'b1;
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        n_cmp++; if ({cyc[0], stb[0]} !== 2'b00) begin n_fail++; $display("FAIL wr_drop: got %b want 00", {cyc[0], stb[0]}); end
        n_cmp++; if ({dack[0], derr[0], ddatr[0]} !== {2'b10, 32'd0}) begin
            n_fail++; $display("FAIL wr_dack: got ack=%b err=%b datr=%h want 1 0 0", dack[0], derr[0], ddatr[0]); end
        n_cmp++; if (cmpl[0] !== 2'b10) begin n_fail++; $display("FAIL wr_complete: got %b want 10", cmpl[0]); end
        n_cmp++; if ({iack[0], ierr[0], taken[0]} !== 4'b0000) begin
            n_fail++; $display("FAIL wr_i_quiet: got %b want 0000", {iack[0], ierr[0], taken[0]}); end
        cmd1[0] = '0;
        tick();
        n_cmp++; if ({dack[0], cmpl[0], cyc[0]} !== 4'b0000) begin
            n_fail++; $display("FAIL wr_after: got %b want 0000", {dack[0], cmpl[0], cyc[0]}); end
    endtask

    task automatic test_i_read_wait();
        cmd0[0] = mk(1'b0, 4'hF, 32'h0000_0100, 32'h0);
        tick();
        n_cmp++; if (taken[0] !== 2'b01) begin n_fail++; $display("FAIL rd_taken: got %b want 01", taken[0]); end
        n_cmp++; if ({cyc[0], we[0], adr[0]} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++; $display("FAIL rd_start: got cyc=%b we=%b adr=%h want 1 0 00000100", cyc[0], we[0], adr[0]); end
        cmd0[0][TB_TAKEN] = 1'b1;
        tick();
        // The latched command must not follow later changes of the queue word.
        cmd0[0][63:32] = 32'h0000_0999;
        tick();
        n_cmp++; if ({cyc[0], adr[0]} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL rd_hold: got cyc=%b adr=%h want 1 00000100", cyc[0], adr[0]); end
        tick();
        n_cmp++; if (cyc[0] !== 1'b1) begin n_fail++; $display("FAIL rd_cyc4: got %b want 1", cyc[0]); end
        ack[0] = 1'b1;
        datr[0] = 32'h1234_5678;
        tick();
        ack[0] = 1'b0;
        datr[0] = 32'hFFFF_FFFF;
        n_cmp++; if ({iack[0], ierr[0], idatr[0]} !== {2'b10, 32'h1234_5678}) begin
            n_fail++; $display("FAIL rd_iack: got ack=%b err=%b datr=%h want 1 0 12345678", iack[0], ierr[0], idatr[0]); end
        n_cmp++; if ({cmpl[0], cyc[0], dack[0]} !== {2'b01, 2'b00}) begin
            n_fail++; $display("FAIL rd_complete: got %b want 0100", {cmpl[0], cyc[0], dack[0]}); end
        cmd0[0] = '0;
        tick();
        datr[0] = 32'h0;
        n_cmp++; if ({iack[0], idatr[0]} !== 33'd0) begin
            n_fail++; $display("FAIL rd_after: got ack=%b datr=%h want 0 0", iack[0], idatr[0]); end
    endtask

    task automatic test_err();
        cmd1[0] = mk(1'b0, 4'hF, 32'h0000_0200, 32'h0);
        tick();
        n_cmp++; if (taken[0] !== 2'b10) begin n_fail++; $display("FAIL err_taken: got %b want 10", taken[0]); end
        cmd1[0][TB_TAKEN] = 1'b1;
        ack[0] = 1'b1;
        err[0] = 1'b1;
        datr[0] = 32'hAAAA_5555;
        tick();
        ack[0] = 1'b0;
        err[0] = 1'b0;
        datr[0] = 32'h0;
        n_cmp++; if ({derr[0], dack[0], ddatr[0]} !== {2'b10, 32'd0}) begin
            n_fail++; $display("FAIL err_d: got err=%b ack=%b datr=%h want 1 0 0", derr[0], dack[0], ddatr[0]); end
        n_cmp++; if ({cmpl[0], iack[0], ierr[0]} !== 4'b1000) begin
            n_fail++; $display("FAIL err_complete: got %b want 1000", {cmpl[0], iack[0], ierr[0]}); end
        cmd1[0] = '0;
        tick();
    endtask

    task automatic test_timeout();
        cmd0[1] = mk(1'b0, 4'hF, 32'h0000_0300, 32'h0);
        tick();
        n_cmp++; if ({cyc[1], taken[1]} !== 3'b101) begin
            n_fail++; $display("FAIL tmo_start: got %b want 101", {cyc[1], taken[1]}); end
        cmd0[1][TB_TAKEN] = 1'b1;
        for (int c = 2; c <= 4; c++) begin
            tick();
            n_cmp++; if (cyc[1] !== 1'b1) begin n_fail++; $display("FAIL tmo_cyc%0d: got %b want 1", c, cyc[1]); end
        end
        tick();
        n_cmp++; if ({cyc[1], stb[1]} !== 2'b00) begin n_fail++; $display("FAIL tmo_drop: got %b want 00", {cyc[1], stb[1]}); end
        n_cmp++; if ({ierr[1], iack[1], idatr[1], cmpl[1]} !== {2'b10, 32'd0, 2'b01}) begin
            n_fail++; $display("FAIL tmo_ierr: got err=%b ack=%b datr=%h cmpl=%b want 1 0 0 01", ierr[1], iack[1], idatr[1], cmpl[1]); end
        cmd0[1] = '0;
        tick();
        n_cmp++; if (ierr[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_after: got %b want 0", ierr[1]); end
    endtask

    // Queue + always-ready slave model; slots are refilled when retired.
    task automatic test_arb(input int k, input int n);
        int got [$];
        int s;
        int want;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cmd0[k] = mk(1'b0, 4'hF, 32'h10, 32'h0);
        cmd1[k] = mk(1'b1, 4'hF, 32'h20, 32'h55);
        for (int c = 0; c < 60 && got.size() < n; c++) begin
            tick();
            if (taken[k][0]) cmd0[k][TB_TAKEN] = 1'b1;
            if (taken[k][1]) cmd1[k][TB_TAKEN] = 1'b1;
            if (cmpl[k] != 2'b00) begin
                s = cmpl[k][1] ? 1 : 0;
                got.push_back(s);
                n_cmp++;
                if ((s == 1 && {dack[k], iack[k]} !== 2'b10) || (s == 0 && {iack[k], dack[k]} !== 2'b10)) begin
                    n_fail++; $display("FAIL arb%0d_port_ack: got i=%b d=%b for slot %0d", k, iack[k], dack[k], s);
                end
                if (s == 1) cmd1[k] = mk(1'b1, 4'hF, 32'h20, 32'h55);
                else        cmd0[k] = mk(1'b0, 4'hF, 32'h10, 32'h0);
            end
            ack[k] = stb[k];
        end
        ack[k] = 1'b0;
        cmd0[k] = '0;
        cmd1[k] = '0;
        n_cmp++;
        if (got.size() != n) begin
            n_fail++; $display("FAIL arb%0d_count: got %0d completions want %0d", k, got.size(), n);
        end
        for (int i = 0; i < got.size(); i++) begin
            want = (k == 0) ? ((i % 2 == 0) ? 1 : 0) : 1;
            n_cmp++;
            if (got[i] != want) begin
                n_fail++; $display("FAIL arb%0d_order[%0d]: got slot %0d want slot %0d", k, i, got[i], want);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        cmd0[0] = mk(1'b0, 4'hF, 32'h0000_0400, 32'h0);
        tick();
        n_cmp++; if (cyc[0] !== 1'b1) begin n_fail++; $display("FAIL rm_start: got %b want 1", cyc[0]); end
        cmd0[0][TB_TAKEN] = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({cyc[0], stb[0], taken[0], cmpl[0], iack[0], ierr[0], dack[0], derr[0]} !== 10'd0) begin
            n_fail++; $display("FAIL rm_async: got %b want 0", {cyc[0], stb[0], taken[0], cmpl[0], iack[0], ierr[0], dack[0], derr[0]});
        end
        cmd0[0] = mk(1'b0, 4'hF, 32'h0000_0400, 32'h0);
        #2;
        rst = 1'b1;
        tick();
        n_cmp++; if ({cyc[0], taken[0], adr[0]} !== {3'b101, 32'h400}) begin
            n_fail++; $display("FAIL rm_rearb: got cyc=%b taken=%b adr=%h want 1 01 00000400", cyc[0], taken[0], adr[0]);
        end
        cmd0[0][TB_TAKEN] = 1'b1;
        ack[0] = 1'b1;
        tick();
        ack[0] = 1'b0;
        n_cmp++; if ({iack[0], cmpl[0]} !== 3'b101) begin
            n_fail++; $display("FAIL rm_ack: got %b want 101", {iack[0], cmpl[0]});
        end
        cmd0[0] = '0;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd0[k] = '0;
            cmd1[k] = '0;
            ack[k]  = 1'b0;
            err[k]  = 1'b0;
            datr[k] = 32'h0;
        end
        test_reset();
        test_d_write();
        test_i_read_wait();
        test_err();
        test_timeout();
        test_arb(0, 4);
        test_arb(1, 3);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
